// File: rtl/issue_pkg.sv
// issue_pkg: shared types and helpers for the issue window.
// Holds the window entry layout, opcode constants and width helpers.
package issue_pkg;

    localparam int OP_W        = 4;
    localparam int REG_NUM_DEF = 16;
    localparam int BID_W_DEF   = 3;
    localparam int IMM_W_DEF   = 5;

    // Register index width; at least one bit even for a single register.
    function automatic int reg_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to n inclusive.
    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int REG_W_DEF = reg_w(REG_NUM_DEF);

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;

    // One window slot; field widths follow the package defaults.
    typedef struct packed {
        logic                 vld;
        logic [OP_W-1:0]      op;
        logic [REG_W_DEF-1:0] des;
        logic [REG_W_DEF-1:0] s1;
        logic [REG_W_DEF-1:0] s2;
        logic [IMM_W_DEF-1:0] imm;
        logic [BID_W_DEF-1:0] bid;
    } win_entry_t;

endpackage

// File: rtl/issue_select.sv
// issue_select: oldest-first pick of up to ISSUE_W ready slots.
// Channel c receives the c-th ready slot counted from slot 0.
module issue_select
    import issue_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ISSUE_W = 4
) (
    input  logic       [ENTRIES-1:0]              ready,
    input  win_entry_t [ENTRIES-1:0]              ent,
    output logic       [ISSUE_W-1:0][ENTRIES-1:0] sel_oh,
    output win_entry_t [ISSUE_W-1:0]              sel_ent,
    output logic       [ENTRIES-1:0]              rm_mask
);

    localparam int CW = $clog2(ISSUE_W + 1);

    logic [CW-1:0] cnt;

    // Priority scan from the oldest slot, filling channels in order.
    always_comb begin
        cnt     = '0;
        sel_oh  = '0;
        sel_ent = '0;
        rm_mask = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready[i] && (cnt < CW'(ISSUE_W))) begin
                for (int c = 0; c < ISSUE_W; c++) begin
                    if (cnt == CW'(c)) begin
                        sel_oh[c][i] = 1'b1;
                        sel_ent[c]   = ent[i];
                    end
                end
                rm_mask[i] = 1'b1;
                cnt        = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_window.sv
// issue_window: age-ordered out-of-order issue window with register scoreboard.
// Optional macro ISSUE_WB_BYPASS_EN: same-cycle writeback wakes dependents.
module issue_window
    import issue_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int DISP_W  = 2,
    parameter int ISSUE_W = 4,
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int BID_W   = BID_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int WB_W    = 4,
    localparam int REG_W  = reg_w(REG_NUM),
    localparam int OCC_W  = occ_w(ENTRIES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DISP_W-1:0]                 disp_vld,
    input  logic [DISP_W-1:0][OP_W-1:0]       disp_op,
    input  logic [DISP_W-1:0][REG_W-1:0]      disp_des,
    input  logic [DISP_W-1:0][REG_W-1:0]      disp_s1,
    input  logic [DISP_W-1:0][REG_W-1:0]      disp_s2,
    input  logic [DISP_W-1:0][IMM_W-1:0]      disp_imm,
    input  logic [DISP_W-1:0][BID_W-1:0]      disp_bid,
    output logic                              disp_rdy,
    input  logic [WB_W-1:0]                   wb_vld,
    input  logic [WB_W-1:0][REG_W-1:0]        wb_des,
    input  logic                              flush_en,
    input  logic [BID_W-1:0]                  flush_id,
    input  logic [REG_NUM-1:0]                flush_reg,
    output logic [ISSUE_W-1:0]                iss_vld,
    output logic [ISSUE_W-1:0][OP_W-1:0]      iss_op,
    output logic [ISSUE_W-1:0][REG_W-1:0]     iss_des,
    output logic [ISSUE_W-1:0][REG_W-1:0]     iss_s1,
    output logic [ISSUE_W-1:0][REG_W-1:0]     iss_s2,
    output logic [ISSUE_W-1:0][IMM_W-1:0]     iss_imm,
    output logic [ISSUE_W-1:0][BID_W-1:0]     iss_bid,
    output logic [OCC_W-1:0]                  occupancy,
    output logic                              win_full,
    output logic                              win_empty
);

    win_entry_t [ENTRIES-1:0]              ent_q, ent_d;
    win_entry_t [ISSUE_W-1:0]              iss_q, iss_d, sel_ent;
    logic       [REG_NUM-1:0]              busy_q, busy_d, busy_eff, wb_mask;
    logic       [OCC_W-1:0]                occ_q, occ_d, idx;
    logic       [ENTRIES-1:0]              ready, rm_mask, keep;
    logic       [ISSUE_W-1:0][ENTRIES-1:0] sel_oh;
    logic       [ISSUE_W-1:0]              sel_vld;

    assign win_full  = occ_q > OCC_W'(ENTRIES - DISP_W);
    assign win_empty = (occ_q == '0);
    assign occupancy = occ_q;
    assign disp_rdy  = !win_full && !flush_en;

    // Registers written back this cycle, one bit per register.
    always_comb begin
        wb_mask = '0;
        for (int k = 0; k < WB_W; k++) begin
            if (wb_vld[k]) wb_mask[wb_des[k]] = 1'b1;
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign busy_eff = busy_q & ~wb_mask;
`else
    assign busy_eff = busy_q;
`endif

    // Readiness: operands and destination idle, no hazard against any older entry.
    always_comb begin
        ready = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = ent_q[i].vld && !flush_en && !busy_eff[ent_q[i].s1] &&
                       !busy_eff[ent_q[i].s2] && !busy_eff[ent_q[i].des];
            for (int j = 0; j < i; j++) begin
                if (ent_q[j].vld &&
                    ((ent_q[j].des == ent_q[i].s1) || (ent_q[j].des == ent_q[i].s2) ||
                     (ent_q[j].des == ent_q[i].des) ||
                     (ent_q[j].s1 == ent_q[i].des) || (ent_q[j].s2 == ent_q[i].des)))
                    ready[i] = 1'b0;
            end
        end
    end

    issue_select #(
        .ENTRIES (ENTRIES),
        .ISSUE_W (ISSUE_W)
    ) u_select (
        .ready   (ready),
        .ent     (ent_q),
        .sel_oh  (sel_oh),
        .sel_ent (sel_ent),
        .rm_mask (rm_mask)
    );

    // Channel valid and next issue registers; unselected channels carry zeros.
    always_comb begin
        for (int c = 0; c < ISSUE_W; c++) sel_vld[c] = |sel_oh[c];
        iss_d = sel_ent;
    end

    // Drop issued/flushed slots, compact toward slot 0, append accepted dispatches.
    always_comb begin
        ent_d = '0;
        idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            keep[i] = ent_q[i].vld && !rm_mask[i] &&
                      !(flush_en && (ent_q[i].bid == flush_id));
            if (keep[i]) begin
                for (int s = 0; s < ENTRIES; s++) begin
                    if (idx == OCC_W'(s)) ent_d[s] = ent_q[i];
                end
                idx = idx + 1'b1;
            end
        end
        for (int ch = 0; ch < DISP_W; ch++) begin
            if (disp_vld[ch] && disp_rdy) begin
                for (int s = 0; s < ENTRIES; s++) begin
                    if (idx == OCC_W'(s)) begin
                        ent_d[s].vld = 1'b1;
                        ent_d[s].op  = disp_op[ch];
                        ent_d[s].des = disp_des[ch];
                        ent_d[s].s1  = disp_s1[ch];
                        ent_d[s].s2  = disp_s2[ch];
                        ent_d[s].imm = disp_imm[ch];
                        ent_d[s].bid = disp_bid[ch];
                    end
                end
                idx = idx + 1'b1;
            end
        end
        occ_d = idx;
    end

    // Scoreboard: writeback clears, flush clears, then issue sets (set wins).
    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (flush_en) busy_d = busy_d & ~flush_reg;
        for (int c = 0; c < ISSUE_W; c++) begin
            if (sel_vld[c]) busy_d[sel_ent[c].des] = 1'b1;
        end
    end

    // State registers; reset empties the window and clears issue outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q  <= '0;
            iss_q  <= '0;
            busy_q <= '0;
            occ_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            iss_q  <= iss_d;
            busy_q <= busy_d;
            occ_q  <= occ_d;
        end
    end

    // Unpack registered issue slots onto the per-field ports.
    always_comb begin
        for (int c = 0; c < ISSUE_W; c++) begin
            iss_vld[c] = iss_q[c].vld;
            iss_op[c]  = iss_q[c].op;
            iss_des[c] = iss_q[c].des;
            iss_s1[c]  = iss_q[c].s1;
            iss_s2[c]  = iss_q[c].s2;
            iss_imm[c] = iss_q[c].imm;
            iss_bid[c] = iss_q[c].bid;
        end
    end

endmodule

// File: tb/tb_issue_window.sv
// tb_issue_window: directed checks of dispatch, issue, hazards, flush, full and reset.
module tb_issue_window;
  import issue_pkg::*;

  localparam int DISP_W  = 2;
  localparam int ISSUE_W = 4;
  localparam int WB_W    = 4;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [DISP_W-1:0]             disp_vld;
  logic [DISP_W-1:0][3:0]        disp_op, disp_des, disp_s1, disp_s2;
  logic [DISP_W-1:0][4:0]        disp_imm;
  logic [DISP_W-1:0][2:0]        disp_bid;
  logic                          disp_rdy;
  logic [WB_W-1:0]               wb_vld;
  logic [WB_W-1:0][3:0]          wb_des;
  logic                          flush_en;
  logic [2:0]                    flush_id;
  logic [15:0]                   flush_reg;
  logic [ISSUE_W-1:0]            iss_vld;
  logic [ISSUE_W-1:0][3:0]       iss_op, iss_des, iss_s1, iss_s2;
  logic [ISSUE_W-1:0][4:0]       iss_imm;
  logic [ISSUE_W-1:0][2:0]       iss_bid;
  logic [3:0]                    occupancy;
  logic                          win_full, win_empty;

  int n_total = 0;
  int n_bad   = 0;

  // clock
  always #5 clk = ~clk;

  issue_window dut (
    .clk(clk), .rst(rst),
    .disp_vld(disp_vld), .disp_op(disp_op), .disp_des(disp_des),
    .disp_s1(disp_s1), .disp_s2(disp_s2), .disp_imm(disp_imm), .disp_bid(disp_bid),
    .disp_rdy(disp_rdy),
    .wb_vld(wb_vld), .wb_des(wb_des),
    .flush_en(flush_en), .flush_id(flush_id), .flush_reg(flush_reg),
    .iss_vld(iss_vld), .iss_op(iss_op), .iss_des(iss_des), .iss_s1(iss_s1),
    .iss_s2(iss_s2), .iss_imm(iss_imm), .iss_bid(iss_bid),
    .occupancy(occupancy), .win_full(win_full), .win_empty(win_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    disp_vld = '0; disp_op = '0; disp_des = '0; disp_s1 = '0; disp_s2 = '0;
    disp_imm = '0; disp_bid = '0;
    wb_vld = '0; wb_des = '0;
    flush_en = 1'b0; flush_id = '0; flush_reg = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    step();
    rst = 1'b0;
  endtask

  task automatic disp(input logic [0:0] ch, input logic [3:0] op, input logic [3:0] des,
                      input logic [3:0] s1, input logic [3:0] s2,
                      input logic [4:0] imm, input logic [2:0] bid);
    disp_vld[ch] = 1'b1;
    disp_op[ch]  = op;
    disp_des[ch] = des;
    disp_s1[ch]  = s1;
    disp_s2[ch]  = s2;
    disp_imm[ch] = imm;
    disp_bid[ch] = bid;
  endtask

  initial begin
    clr_in();
    #2;
    do_reset();

    // reset state
    check("rst_iss_vld", iss_vld, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", win_empty, 1);
    check("rst_full", win_full, 0);
    check("rst_rdy", disp_rdy, 1);
    check("rst_des0", iss_des[0], 0);

    // two independent ops issue together on channels 0 and 1
    disp(0, OP_ADD, 1, 2, 3, 5, 1);
    disp(1, OP_SUB, 4, 5, 6, 9, 2);
    step();
    disp_vld = '0;
    check("t1_occ_in", occupancy, 2);
    check("t1_vld_early", iss_vld, 0);
    step();
    check("t1_vld", iss_vld, 4'b0011);
    check("t1_des0", iss_des[0], 1);
    check("t1_des1", iss_des[1], 4);
    check("t1_s1_1", iss_s1[1], 5);
    check("t1_s2_0", iss_s2[0], 3);
    check("t1_imm0", iss_imm[0], 5);
    check("t1_op1", iss_op[1], OP_SUB);
    check("t1_bid1", iss_bid[1], 2);
    check("t1_occ_out", occupancy, 0);
    check("t1_empty", win_empty, 1);
    step();
    check("t1_vld_idle", iss_vld, 0);
    check("t1_des0_idle", iss_des[0], 0);

    // RAW dependency woken by writeback
    do_reset();
    disp(0, OP_ADD, 1, 2, 3, 0, 0);
    disp(1, OP_AND, 7, 1, 1, 0, 0);
    step();
    disp_vld = '0;
    check("t2_occ2", occupancy, 2);
    step();
    check("t2_vld_a", iss_vld, 4'b0001);
    check("t2_des_a", iss_des[0], 1);
    check("t2_occ1", occupancy, 1);
    step();
    check("t2_wait", iss_vld, 0);
    wb_vld = 4'b0001;
    wb_des[0] = 4'd1;
    step();
    wb_vld = '0;
`ifdef ISSUE_WB_BYPASS_EN
    check("t2_byp_vld", iss_vld, 4'b0001);
    check("t2_byp_des", iss_des[0], 7);
    check("t2_byp_occ", occupancy, 0);
    step();
    check("t2_byp_after", iss_vld, 0);
`else
    check("t2_wb_edge", iss_vld, 0);
    check("t2_wb_occ", occupancy, 1);
    step();
    check("t2_vld_b", iss_vld, 4'b0001);
    check("t2_des_b", iss_des[0], 7);
    check("t2_s1_b", iss_s1[0], 1);
    check("t2_occ0", occupancy, 0);
`endif

    // fill the window with ops chained on r1
    do_reset();
    disp(0, OP_ADD, 1, 2, 3, 0, 0);
    step();
    disp_vld = '0;
    for (int g = 0; g < 3; g++) begin
      disp(0, OP_OR, 1, 1, 1, 0, 1);
      disp(1, OP_OR, 1, 1, 1, 0, 1);
      step();
      disp_vld = '0;
    end
    check("t3_occ6", occupancy, 6);
    check("t3_nfull6", win_full, 0);
    check("t3_rdy6", disp_rdy, 1);
    disp(0, OP_OR, 1, 1, 1, 0, 1);
    step();
    disp_vld = '0;
    check("t3_occ7", occupancy, 7);
    check("t3_full7", win_full, 1);
    check("t3_rdy7", disp_rdy, 0);
    disp(0, OP_OR, 1, 1, 1, 0, 1);
    disp(1, OP_OR, 1, 1, 1, 0, 1);
    step();
    step();
    disp_vld = '0;
    check("t3_hold_occ", occupancy, 7);
    check("t3_hold_full", win_full, 1);
    check("t3_no_iss", iss_vld, 0);
    check("t3_nempty", win_empty, 0);

    // branch flush of bid 2
    do_reset();
    disp(0, OP_ADD, 1, 2, 3, 0, 0);
    step();
    disp_vld = '0;
    disp(0, OP_ADD, 1, 1, 1, 1, 2);
    disp(1, OP_SUB, 1, 1, 1, 2, 3);
    step();
    disp_vld = '0;
    disp(0, OP_AND, 1, 1, 1, 3, 2);
    disp(1, OP_OR, 1, 1, 1, 4, 5);
    step();
    disp_vld = '0;
    check("t4_occ4", occupancy, 4);
    flush_en = 1'b1;
    flush_id = 3'd2;
    flush_reg = 16'h0002;
    #1;
    check("t4_rdy_flush", disp_rdy, 0);
    step();
    clr_in();
    check("t4_occ2", occupancy, 2);
    check("t4_no_iss", iss_vld, 0);
    step();
    check("t4_iss_vld", iss_vld, 4'b0001);
    check("t4_iss_bid", iss_bid[0], 3);
    check("t4_iss_imm", iss_imm[0], 2);
    check("t4_occ1", occupancy, 1);
    step();
    check("t4_blocked", iss_vld, 0);

    // six ready entries, four issue then two
    do_reset();
    disp(0, OP_ADD, 15, 14, 14, 0, 0);
    step();
    disp_vld = '0;
    for (int g = 0; g < 3; g++) begin
      disp(0, OP_ADD, 4'(2*g+1), 15, 4'(2*g+9), 5'(2*g+1), 0);
      disp(1, OP_ADD, 4'(2*g+2), 15, 4'(2*g+10), 5'(2*g+2), 0);
      step();
      disp_vld = '0;
    end
    check("t5_occ6", occupancy, 6);
    step();
    check("t5_wait", iss_vld, 0);
    wb_vld = 4'b0100;
    wb_des[2] = 4'd15;
    step();
    wb_vld = '0;
`ifndef ISSUE_WB_BYPASS_EN
    check("t5_wb_edge", iss_vld, 0);
    step();
`endif
    check("t5_vld4", iss_vld, 4'b1111);
    check("t5_des0", iss_des[0], 1);
    check("t5_des1", iss_des[1], 2);
    check("t5_des2", iss_des[2], 3);
    check("t5_des3", iss_des[3], 4);
    check("t5_s2_3", iss_s2[3], 12);
    check("t5_occ2", occupancy, 2);
    step();
    check("t5_vld2", iss_vld, 4'b0011);
    check("t5_des0b", iss_des[0], 5);
    check("t5_des1b", iss_des[1], 6);
    check("t5_imm1b", iss_imm[1], 6);
    check("t5_empty", win_empty, 1);

    // asynchronous reset with a busy window
    do_reset();
    disp(0, OP_ADD, 15, 14, 14, 0, 0);
    step();
    disp_vld = '0;
    disp(0, OP_ADD, 1, 15, 15, 0, 0);
    disp(1, OP_ADD, 2, 15, 15, 0, 0);
    step();
    disp_vld = '0;
    disp(0, OP_ADD, 3, 15, 15, 0, 0);
    disp(1, OP_ADD, 4, 15, 15, 0, 0);
    step();
    disp_vld = '0;
    disp(0, OP_SUB, 10, 11, 12, 0, 0);
    disp(1, OP_SUB, 13, 11, 12, 0, 0);
    step();
    disp_vld = '0;
    disp(0, OP_ADD, 5, 15, 15, 0, 0);
    step();
    disp_vld = '0;
    check("t6_pre_vld", iss_vld, 4'b0011);
    check("t6_pre_des0", iss_des[0], 10);
    check("t6_pre_des1", iss_des[1], 13);
    check("t6_pre_occ", occupancy, 5);
    #2;
    rst = 1'b1;
    #1;
    check("t6_vld", iss_vld, 0);
    check("t6_des1", iss_des[1], 0);
    check("t6_occ", occupancy, 0);
    check("t6_empty", win_empty, 1);
    check("t6_full", win_full, 0);
    step();
    rst = 1'b0;
    check("t6_rdy", disp_rdy, 1);
    disp(0, OP_OR, 2, 15, 15, 0, 0);
    step();
    disp_vld = '0;
    step();
    check("t6_busy_clr_vld", iss_vld, 4'b0001);
    check("t6_busy_clr_des", iss_des[0], 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // run-time bound
  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/issue_window.md
# issue_window

Parametrised out-of-order issue window that replaces the fixed four-slot issue stage. It takes up to DISP_W decoded instructions per cycle into an age-ordered window of ENTRIES slots and tracks pending destinations in a register scoreboard. Each cycle it selects up to ISSUE_W hazard-free instructions, oldest first, and registers them onto the execute-side issue ports. It sits between decode and the execution lanes, and also takes writeback and branch-flush inputs.

## Interface
- ENTRIES, 8: window depth, ≥ DISP_W+1.
- DISP_W, 2: dispatch channels per cycle.
- ISSUE_W, 4: issue channels per cycle.
- REG_NUM, 16: architectural registers; REG_W = $clog2(REG_NUM).
- BID_W, 3: branch-id width.
- IMM_W, 5: immediate width.
- WB_W, 4: writeback channels.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- disp_vld  in  DISP_W  per-channel dispatch valid.
- disp_op / disp_des / disp_s1 / disp_s2  in  DISP_W×4 / DISP_W×REG_W ×3  decoded fields.
- disp_imm  in  DISP_W×IMM_W  immediate.
- disp_bid  in  DISP_W×BID_W  branch id.
- disp_rdy  out  1  window accepts a full dispatch group this cycle.
- wb_vld  in  WB_W  writeback valid.
- wb_des  in  WB_W×REG_W  writeback destination.
- flush_en  in  1  branch mispredict flush.
- flush_id  in  BID_W  branch id to squash.
- flush_reg  in  REG_NUM  scoreboard bits to clear.
- iss_vld  out  ISSUE_W  issue valid, registered.
- iss_op / iss_des / iss_s1 / iss_s2 / iss_imm / iss_bid  out  per-channel fields, registered.
- occupancy  out  $clog2(ENTRIES+1)  valid entry count.
- win_full  out  1  occupancy > ENTRIES−DISP_W.
- win_empty  out  1  occupancy == 0.

## Operation
- Window:
  - Entries are held in age order; slot 0 is the oldest.
  - Each cycle, issued or flushed entries are removed, survivors compact toward slot 0, and accepted dispatches append at the tail in channel order (channel 0 is older).
- Dispatch:
  - disp_rdy = !win_full && !flush_en.
  - A channel is written only when disp_vld[i] && disp_rdy.
  - When disp_rdy=0, the whole group is dropped; upstream holds it.
- Scoreboard: a busy[REG_NUM] vector.
  - Set on issue of a destination.
  - Cleared on wb_vld[k] for wb_des[k].
  - Set and clear of the same register in one cycle: set wins, because it belongs to the new writer.
- An entry is ready when all of the following hold:
  - busy[s1], busy[s2] and busy[des] are all 0.
  - No older valid entry has des equal to its s1, s2 or des (RAW/WAW).
  - No older valid entry has s1 or s2 equal to its des (WAR).
- Selection:
  - Scan from slot 0 and take the first ISSUE_W ready entries.
  - Fill issue channel 0 first, in age order.
  - Because of the older-entry checks, no two selected entries conflict.
- Flush:
  - When flush_en=1, invalidate every entry with bid == flush_id.
  - Clear busy[r] for each set bit of flush_reg.
  - Issue nothing that cycle and accept no dispatch.
  - flush_reg is applied after writeback clears.

## Timing
- Dispatch at edge N: the entry is visible to selection in cycle N+1 and appears on iss_* at edge N+2 at the earliest.
- Issue outputs are registered: selection in cycle N drives iss_* after edge N+1.
  - iss_vld is deasserted in any cycle with nothing selected.
  - Fields of invalid channels are 0.
- Writeback at edge N clears busy and wakes dependents for selection in cycle N+1 (see Configuration for bypass).
- Reset values:
  - Entries invalid; busy all 0.
  - iss_vld=0 and all iss_* fields 0.
  - occupancy=0, win_empty=1, win_full=0.
  - disp_rdy=1 once rst is released.
- Reset mid-operation drops all window contents asynchronously.
- Occupancy arithmetic is next = cur − removed + accepted and never exceeds ENTRIES; win_full guarantees room for DISP_W.
- Simultaneous events:
  - Issue and dispatch in the same cycle are both processed.
  - Flush overrides issue and dispatch.
  - An entry that is both flushed and ready is flushed.

## Configuration
- ISSUE_WB_BYPASS_EN defined:
  - Registers written back in the current cycle are treated as not busy during selection that same cycle.
  - Dependents therefore issue at the edge of the writeback.
- ISSUE_WB_BYPASS_EN undefined: one-cycle wakeup after writeback, as described in Timing.

## Structure
- Package issue_pkg holds:
  - The win_entry_t struct (vld, op, des, s1, s2, imm, bid).
  - Opcode constants.
  - REG_W/occupancy width helper functions.
- Sub-module issue_select (combinational):
  - Inputs: ready vector and entry array.
  - Outputs: ISSUE_W one-hot slot indices and the removal mask, via an oldest-first priority pick.
- Compaction, scoreboard and output registers live in issue_window.

## Test plan
- Reset, then dispatch the independent ops r1←r2,r3 and r4←r5,r6 -> both issue together two cycles later on channels 0 and 1; occupancy returns to 0.
- Dispatch r1←r2,r3 then r7←r1,r1; wb r1 three cycles later -> the second op issues one cycle after wb without bypass, and on the wb cycle's edge with ISSUE_WB_BYPASS_EN.
- Fill the window with 8 mutually dependent ops on r1 -> win_full=1 at occupancy 7; disp_rdy=0; further groups are not accepted and no overflow occurs.
- Window holds bids 2,3,2,5; flush_en with flush_id=2 and flush_reg=16'h0002 -> both bid-2 entries are removed, busy[1] is cleared, nothing issues that cycle, and occupancy drops by 2.
- Six independent ready entries with ISSUE_W=4 -> the oldest four issue in age order; the remaining two issue the next cycle.
- Assert rst while the window holds 5 entries and iss_vld=4'b0011 -> all outputs are 0 immediately, win_empty=1, and busy is cleared.
